motoro3_gate_deadtime: RTL and testbench

Downstream stage of the three-phase commutation state machine. Converts each phase's enable, high/low select and the shared PWM chop signal into six individual gate drives: a high-side and a low-side gate per phase. Inserts a programmable dead time before any gate turns on, so the two switches of one leg are never driven together. Adds a latched fault shutdown that forces all gates off.

---
 rtl/motoro3_pkg.sv | 25 ++
 rtl/motoro3_deadtime_phase.sv | 95 +++++++++
 rtl/motoro3_gate_deadtime.sv | 87 ++++++++
 tb/tb_motoro3_gate_deadtime.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_pkg.sv
// Shared encodings for the motoro3 gate dead-time stage: phase FSM states,
// phase request values and the default dead time.
package motoro3_pkg;

    localparam logic [1:0] S_OFF = 2'd0;
    localparam logic [1:0] S_DT  = 2'd1;
    localparam logic [1:0] S_HI  = 2'd2;
    localparam logic [1:0] S_LO  = 2'd3;

    typedef enum logic [1:0] {
        REQ_OFF = 2'd0,
        REQ_HI  = 2'd1,
        REQ_LO  = 2'd2
    } req_e;

    localparam int DT_CYCLES_DEF = 10;

    // The PWM chop only gates the high side; the low side ignores it.
    function automatic req_e decode_req(input logic en, input logic h1_l0, input logic pwm);
        if (en && h1_l0 && pwm) return REQ_HI;
        if (en && !h1_l0)       return REQ_LO;
        return REQ_OFF;
    endfunction

endpackage

// File: rtl/motoro3_deadtime_phase.sv
// One inverter leg: request decode, dead-time FSM and registered gate drives.
// state | meaning
// S_OFF | both gates off, idle
// S_DT  | both gates off, dead time running toward tgt
// S_HI  | high-side gate on
// S_LO  | low-side gate on
module motoro3_deadtime_phase
    import motoro3_pkg::*;
#(
    parameter int DT_CYCLES = DT_CYCLES_DEF,
    parameter int DT_W      = 8
) (
    input  logic clk,
    input  logic nRst,
    input  logic force_off_i,
    input  logic en_i,
    input  logic h1_l0_i,
    input  logic pwm_i,
    output logic hg_o,
    output logic lg_o,
    output logic dt_active_o
);

    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    req_e            tgt_q, tgt_d;
    req_e            req;
    logic            on_held;
    logic            hg_q, lg_q;

    always_comb begin
        req     = decode_req(en_i, h1_l0_i, pwm_i);
        on_held = ((state_q == S_HI) && (req == REQ_HI)) ||
                  ((state_q == S_LO) && (req == REQ_LO));
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        if (force_off_i) begin
            state_d = S_OFF;
            tgt_d   = REQ_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (req != REQ_OFF) begin
                        state_d = S_DT;
                        cnt_d   = DT_LOAD;
                        tgt_d   = req;
                    end
                end
                S_HI, S_LO: begin
                    // Reload on every exit so a re-entry can never shortcut the dead time.
                    if (!on_held) begin
                        state_d = S_DT;
                        cnt_d   = DT_LOAD;
                        tgt_d   = req;
                    end
                end
                S_DT: begin
                    if (req == REQ_OFF) begin
                        state_d = S_OFF;
                    end else if (cnt_q == '0) begin
                        state_d = (req == REQ_HI) ? S_HI : S_LO;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        tgt_d = req;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            tgt_q   <= REQ_OFF;
            hg_q    <= 1'b0;
            lg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            hg_q    <= (state_d == S_HI);
            lg_q    <= (state_d == S_LO);
        end
    end

    assign hg_o        = hg_q;
    assign lg_o        = lg_q;
    assign dt_active_o = (state_q == S_DT);

endmodule

// File: rtl/motoro3_gate_deadtime.sv
// Three-phase gate driver with per-leg dead time and a latched fault shutdown
// that forces every leg off. All registers update on the falling clk edge.
module motoro3_gate_deadtime
    import motoro3_pkg::*;
#(
    parameter int DT_CYCLES = DT_CYCLES_DEF,
    parameter int DT_W      = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       pwm,
    input  logic       aE,
    input  logic       bE,
    input  logic       cE,
    input  logic       aH1_L0,
    input  logic       bH1_L0,
    input  logic       cH1_L0,
    input  logic       fault_in,
    input  logic       fault_clr,
    output logic       aHg,
    output logic       aLg,
    output logic       bHg,
    output logic       bLg,
    output logic       cHg,
    output logic       cLg,
    output logic       fault_latched,
    output logic [2:0] dt_active
);

    if (DT_CYCLES < 1 || DT_CYCLES > 255 || DT_CYCLES > (2 ** DT_W)) begin : g_dt_range
        $error("motoro3_gate_deadtime: DT_CYCLES out of range");
    end

    logic       fault_q, fault_d;
    logic       force_off;
    logic [2:0] en, h1_l0, hg, lg, dt;

    always_comb begin
        fault_d = fault_q;
        if (fault_in) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(negedge clk or negedge nRst) begin
        if (!nRst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    // A fresh fault sample kills the gates at the same edge it is latched.
    assign force_off = fault_q | fault_in;

    assign en    = {cE, bE, aE};
    assign h1_l0 = {cH1_L0, bH1_L0, aH1_L0};

    for (genvar p = 0; p < 3; p++) begin : g_phase
        motoro3_deadtime_phase #(
            .DT_CYCLES (DT_CYCLES),
            .DT_W      (DT_W)
        ) u_phase (
            .clk         (clk),
            .nRst        (nRst),
            .force_off_i (force_off),
            .en_i        (en[p]),
            .h1_l0_i     (h1_l0[p]),
            .pwm_i       (pwm),
            .hg_o        (hg[p]),
            .lg_o        (lg[p]),
            .dt_active_o (dt[p])
        );
    end

    assign aHg           = hg[0];
    assign aLg           = lg[0];
    assign bHg           = hg[1];
    assign bLg           = lg[1];
    assign cHg           = hg[2];
    assign cLg           = lg[2];
    assign fault_latched = fault_q;
    assign dt_active     = dt;

endmodule

// File: tb/tb_motoro3_gate_deadtime.sv
// Directed bench for motoro3_gate_deadtime with DT_CYCLES = 10. Inputs change
// just after the rising edge; outputs are sampled there, after the falling edge.
module tb_motoro3_gate_deadtime;

    logic       clk;
    logic       nRst;
    logic       pwm;
    logic       aE, bE, cE;
    logic       aH1_L0, bH1_L0, cH1_L0;
    logic       fault_in, fault_clr;
    logic       aHg, aLg, bHg, bLg, cHg, cLg;
    logic       fault_latched;
    logic [2:0] dt_active;
    logic [9:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    motoro3_gate_deadtime dut (
        .clk           (clk),
        .nRst          (nRst),
        .pwm           (pwm),
        .aE            (aE),
        .bE            (bE),
        .cE            (cE),
        .aH1_L0        (aH1_L0),
        .bH1_L0        (bH1_L0),
        .cH1_L0        (cH1_L0),
        .fault_in      (fault_in),
        .fault_clr     (fault_clr),
        .aHg           (aHg),
        .aLg           (aLg),
        .bHg           (bHg),
        .bLg           (bLg),
        .cHg           (cHg),
        .cLg           (cLg),
        .fault_latched (fault_latched),
        .dt_active     (dt_active)
    );

    // {aHg,aLg,bHg,bLg,cHg,cLg,fault_latched,dt_active[2:0]}
    assign obs = {aHg, aLg, bHg, bLg, cHg, cLg, fault_latched, dt_active};

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) begin
        if (nRst) begin
            n_tests++;
            if ((aHg & aLg) | (bHg & bLg) | (cHg & cLg)) begin
                n_fail++;
                $display("FAIL overlap t=%0t got a=%b%b b=%b%b c=%b%b exp no leg with both gates on",
                         $time, aHg, aLg, bHg, bLg, cHg, cLg);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        aE = 1'b1; bE = 1'b1; cE = 1'b1;
        aH1_L0 = 1'b1; bH1_L0 = 1'b0; cH1_L0 = 1'b1;
        pwm = 1'b1; fault_in = 1'b1; fault_clr = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_held got %h exp %h", obs, 10'h000);
        end
        aE = 1'b0; bE = 1'b0; cE = 1'b0; fault_in = 1'b0;
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (obs !== 10'h000) begin
                n_fail++;
                $display("FAIL reset_release i=%0d got %h exp %h", i, obs, 10'h000);
            end
        end
    endtask

    task automatic test_turn_on();
        logic [9:0] exp;
        aE = 1'b1; aH1_L0 = 1'b1; pwm = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            exp = (i < 10) ? 10'h001 : 10'h200;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL turn_on edge k+%0d got %h exp %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_swap();
        logic [9:0] exp;
        aH1_L0 = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            exp = (i < 10) ? 10'h001 : 10'h100;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL swap_hi_lo edge k+%0d got %h exp %h", i, obs, exp);
            end
        end
        aH1_L0 = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            exp = (i < 10) ? 10'h001 : 10'h200;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL swap_lo_hi edge k+%0d got %h exp %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_chop();
        logic [9:0] exp;
        pwm = 1'b0;
        for (int i = 0; i <= 14; i++) begin
            if (i == 4) pwm = 1'b1;
            tick();
            if (i == 0)      exp = 10'h001;
            else if (i < 4)  exp = 10'h000;
            else if (i < 14) exp = 10'h001;
            else             exp = 10'h200;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL chop edge k+%0d got %h exp %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_revert();
        logic [9:0] exp;
        aH1_L0 = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i == 3) aH1_L0 = 1'b1;
            tick();
            exp = (i < 10) ? 10'h001 : 10'h200;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL revert edge k+%0d got %h exp %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_fault();
        logic [9:0] exp;
        bE = 1'b1; bH1_L0 = 1'b1; cE = 1'b1; cH1_L0 = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            exp = (i < 10) ? 10'h206 : 10'h2A0;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL fault_setup edge %0d got %h exp %h", i, obs, exp);
            end
        end
        fault_in = 1'b1;
        tick();
        n_tests++;
        if (obs !== 10'h008) begin
            n_fail++;
            $display("FAIL fault_trip got %h exp %h", obs, 10'h008);
        end
        fault_clr = 1'b1;
        tick();
        n_tests++;
        if (obs !== 10'h008) begin
            n_fail++;
            $display("FAIL fault_clr_ignored got %h exp %h", obs, 10'h008);
        end
        fault_in = 1'b0; fault_clr = 1'b0;
        tick();
        n_tests++;
        if (obs !== 10'h008) begin
            n_fail++;
            $display("FAIL fault_hold got %h exp %h", obs, 10'h008);
        end
        fault_clr = 1'b1;
        tick();
        n_tests++;
        if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL fault_clear edge j got %h exp %h", obs, 10'h000);
        end
        fault_clr = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            exp = (i <= 10) ? 10'h007 : 10'h2A0;
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL fault_recover edge j+%0d got %h exp %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_simultaneity();
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0; fault_clr = 1'b1;
        tick();
        n_tests++;
        if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL simul_clear got %h exp %h", obs, 10'h000);
        end
        fault_clr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_tests++;
            if (obs !== 10'h007) begin
                n_fail++;
                $display("FAIL simul_dt edge j+%0d got %h exp %h", i, obs, 10'h007);
            end
        end
        fault_in = 1'b1;
        tick();
        n_tests++;
        if (obs !== 10'h008) begin
            n_fail++;
            $display("FAIL simul_fault_at_tc got %h exp %h", obs, 10'h008);
        end
        fault_in = 1'b0;
        tick();
        n_tests++;
        if (obs !== 10'h008) begin
            n_fail++;
            $display("FAIL simul_stays_off got %h exp %h", obs, 10'h008);
        end
    endtask

    task automatic test_reset_mid();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        repeat (11) tick();
        n_tests++;
        if (obs !== 10'h2A0) begin
            n_fail++;
            $display("FAIL reset_mid_setup got %h exp %h", obs, 10'h2A0);
        end
        #20;
        nRst = 1'b0;
        #1;
        n_tests++;
        if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_mid_async got %h exp %h", obs, 10'h000);
        end
        aE = 1'b0; bE = 1'b0; cE = 1'b0;
        #5;
        nRst = 1'b1;
        tick();
        n_tests++;
        if (obs !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_mid_after got %h exp %h", obs, 10'h000);
        end
    endtask

    initial begin
        nRst = 1'b0;
        pwm = 1'b0;
        aE = 1'b0; bE = 1'b0; cE = 1'b0;
        aH1_L0 = 1'b0; bH1_L0 = 1'b0; cH1_L0 = 1'b0;
        fault_in = 1'b0; fault_clr = 1'b0;
        test_reset();
        test_turn_on();
        test_swap();
        test_chop();
        test_revert();
        test_fault();
        test_simultaneity();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
